seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 23 ++
 rtl/seven_seg_scan_ctrl_if.sv | 24 ++
 rtl/scan_phase_cnt.sv | 38 +++
 rtl/seven_seg_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned BCD_MAX    = 9;
    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StDrive
    } scan_state_e;

    // One-hot select for a digit index, sized for the largest supported display.
    function automatic logic [MAX_DIGITS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_DIGITS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake carrying new display contents into the scan controller.
interface seven_seg_scan_ctrl_if
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) ();

    logic                          load_valid;
    logic [BCD_W*NUM_DIGITS-1:0]   load_data;
    logic                          load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/scan_phase_cnt.sv
// Loadable down-counter timing the BLANK and DRIVE phases; tc marks the last cycle.
module scan_phase_cnt #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Clear wins over load; otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode seven-segment display.
// Display contents arrive over a valid/ready handshake and are committed only at
// frame boundaries (or while idle) so a frame never shows mixed contents.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    seven_seg_scan_ctrl_if.slave  ld,
    output logic [BCD_W-1:0]      bcd,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done
);

    localparam int unsigned MaxLen = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxLen) + 1;
    localparam int unsigned DataW  = BCD_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DataW-1:0]       display_q, display_d;
    logic [DataW-1:0]       shadow_q, shadow_d;
    logic                   pending_q, pending_d;
    logic                   ready_q, ready_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]  digit_en_q, digit_en_d;
    logic                   frame_done_q, frame_done_d;

    logic                   cnt_clear, cnt_load, cnt_tc;
    logic [CntW-1:0]        cnt_val;
    logic                   enter_frame, xfer, commit;
    logic [BCD_W-1:0]       nib;
    logic [MAX_DIGITS-1:0]  onehot_full;
    logic                   unused_onehot;

    scan_phase_cnt #(
        .WIDTH (CntW)
    ) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    // Scan sequencing: phase transitions, digit stepping and counter control.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        frame_done_d = 1'b0;
        enter_frame  = 1'b0;
        if (!enable) begin
            state_d   = StIdle;
            idx_d     = '0;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d     = StBlank;
                    idx_d       = '0;
                    cnt_load    = 1'b1;
                    cnt_val     = CntW'(BLANK_CYCLES - 1);
                    enter_frame = 1'b1;
                end
                StBlank: begin
                    if (cnt_tc) begin
                        state_d  = StDrive;
                        cnt_load = 1'b1;
                        cnt_val  = CntW'(REFRESH_DIV - 1);
                    end
                end
                StDrive: begin
                    if (cnt_tc) begin
                        state_d  = StBlank;
                        cnt_load = 1'b1;
                        cnt_val  = CntW'(BLANK_CYCLES - 1);
                        if (idx_q == LastIdx) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                            enter_frame  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Load handshake: accept into the shadow, commit at frame start or while idle.
    always_comb begin
        xfer      = ld.load_valid & ready_q;
        commit    = pending_q & (enter_frame | (state_q == StIdle));
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        if (commit) begin
            display_d = shadow_q;
            pending_d = 1'b0;
            ready_d   = 1'b1;
        end else if (xfer) begin
            shadow_d  = ld.load_data;
            pending_d = 1'b1;
            ready_d   = 1'b0;
        end
    end

    // Outputs are computed from next state so the registered copies line up with state_q.
    always_comb begin
        nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib = display_d[BCD_W*i +: BCD_W];
            end
        end
        onehot_full = idx_onehot(idx_d);
        bcd_d       = (state_d == StIdle) ? '0 : nib;
        digit_en_d  = '0;
        // Codes above 9 are blanked rather than handed to the decoder.
        if ((state_d == StDrive) && (nib <= BCD_W'(BCD_MAX))) begin
            digit_en_d = onehot_full[NUM_DIGITS-1:0];
        end
    end

    assign unused_onehot = ^onehot_full;

    // State, data and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            display_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            ready_q      <= 1'b1;
            bcd_q        <= '0;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            display_q    <= display_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            ready_q      <= ready_d;
            bcd_q        <= bcd_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ld.load_ready = ready_q;
    assign bcd           = bcd_q;
    assign digit_en      = digit_en_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: a frame-position model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the controller.
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int DP = RD + BC;
    localparam int FP = ND * DP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [3:0]    bcd;
    logic [ND-1:0] digit_en;
    logic          frame_done;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) ld_if ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .ld         (ld_if),
        .bcd        (bcd),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    bcd;
        logic [ND-1:0] en;
        logic          fd;
        logic          rdy;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: position within the frame plus committed/shadow contents.
    bit          m_run;
    int          m_t;
    logic [3:0]  m_disp[ND];
    logic [15:0] m_shadow;
    bit          m_pend;
    bit          m_rdy;
    bit          m_xfer;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_t = 0; m_shadow = '0; m_pend = 0; m_rdy = 1; m_xfer = 0;
        for (int i = 0; i < ND; i++) m_disp[i] = '0;
        exp_q.delete();
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void model_edge();
        bit   commit;
        bit   fd;
        bit   xfer;
        int   d;
        int   w;
        exp_t e;
        commit = 0;
        fd     = 0;
        xfer   = ld_if.load_valid && m_rdy;
        if (!enable) begin
            commit = m_pend && !m_run;
            m_run  = 0;
            m_t    = 0;
        end else if (!m_run) begin
            m_run  = 1;
            m_t    = 0;
            commit = m_pend;
        end else begin
            m_t++;
            if (m_t == FP) begin
                m_t    = 0;
                fd     = 1;
                commit = m_pend;
            end
        end
        m_xfer = xfer;
        if (commit) begin
            for (int i = 0; i < ND; i++) m_disp[i] = m_shadow[4*i +: 4];
            m_pend = 0;
            m_rdy  = 1;
        end else if (xfer) begin
            m_shadow = ld_if.load_data;
            m_pend   = 1;
            m_rdy    = 0;
        end
        e.fd  = fd;
        e.rdy = m_rdy;
        e.bcd = '0;
        e.en  = '0;
        if (m_run) begin
            d     = m_t / DP;
            w     = m_t % DP;
            e.bcd = m_disp[d];
            if (w >= BC && m_disp[d] <= 4'd9) e.en = ND'(1 << d);
        end
        exp_q.push_back(e);
    endfunction

    // One clock: the model sees the same inputs the DUT samples, then inputs may change.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] data);
        bit done;
        done = 0;
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = data;
        for (int i = 0; i < 2 * FP && !done; i++) begin
            tick();
            done = m_xfer;
        end
        ld_if.load_valid = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL load_accept: got no transfer expected transfer of %h", data);
        end
    endtask

    // Run until the model's frame position lies in [lo,hi].
    task automatic wait_pos(input int lo, input int hi);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2 * FP && !hit; i++) begin
            if (m_run && m_t >= lo && m_t <= hi) hit = 1;
            else tick();
        end
        if (!hit) begin
            errors++;
            $display("FAIL wait_pos: got position %0d expected %0d..%0d", m_t, lo, hi);
        end
    endtask

    // Monitor: every cycle presents outputs; compare against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bcd !== e.bcd || digit_en !== e.en || frame_done !== e.fd ||
                ld_if.load_ready !== e.rdy) begin
                errors++;
                $display("FAIL scan @%0t: got bcd=%h en=%b fd=%b rdy=%b expected bcd=%h en=%b fd=%b rdy=%b",
                         $time, bcd, digit_en, frame_done, ld_if.load_ready,
                         e.bcd, e.en, e.fd, e.rdy);
            end
        end
    end

    initial begin
        ld_if.load_valid = 1'b0;
        ld_if.load_data  = '0;
        model_reset();

        #12;
        check("reset_bcd", int'(bcd), 0);
        check("reset_digit_en", int'(digit_en), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_load_ready", int'(ld_if.load_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Blank scan of zeros, then directed loads.
        run(3);
        enable = 1'b1;
        run(FP + 5);
        do_load(16'h4321);
        run(2 * FP);
        wait_pos(2 * DP + BC, 3 * DP - 1);
        do_load(16'h9876);
        run(2 * FP);
        do_load(16'h0A05);
        run(2 * FP);
        wait_pos(DP + BC, 2 * DP - 1);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(FP + 3);

        // Load while disabled: committed from idle.
        enable = 1'b0;
        run(2);
        do_load(16'hB7C2);
        run(3);
        enable = 1'b1;
        run(FP);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (enable) begin
                if ($urandom_range(0, 99) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 9) < 3) begin
                enable = 1'b1;
            end
            if (ld_if.load_valid && m_xfer) ld_if.load_valid = 1'b0;
            if (!ld_if.load_valid && $urandom_range(0, 19) == 0) begin
                ld_if.load_valid = 1'b1;
                ld_if.load_data  = 16'($urandom);
            end
            tick();
        end
        ld_if.load_valid = 1'b0;
        enable = 1'b1;
        run(FP + 2);

        // Asynchronous reset mid-DRIVE with a load still pending.
        wait_pos(BC, DP / 2);
        do_load(16'h5555);
        wait_pos(DP + BC, 2 * DP - 2);
        check("pending_before_reset_ready", int'(ld_if.load_ready), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_bcd", int'(bcd), 0);
        check("async_rst_digit_en", int'(digit_en), 0);
        check("async_rst_frame_done", int'(frame_done), 0);
        check("async_rst_load_ready", int'(ld_if.load_ready), 1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        run(2);
        enable = 1'b1;
        run(FP + 4);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
